mult_sched: RTL and testbench
=============================

// Module: mult_sched
// PURPOSE
//  Round-robin scheduler sharing one sequential signed multiplier (mult) among N requesters.
//  Latches the winner's operands, drives mult's start/ready handshake and returns the 32-bit product.
//  Sits between mult and the client blocks needing products.
// PARAMETERS
//  N         4   number of requesters (2..8)
//  DATA_W    16  signed operand width
//  START_CYC 2   cycles m_start is held high per operation
// PORTS
//  clk     in   1          clock, rising edge
//  rst     in   1          reset, asynchronous, active-high
//  req     in   N          req[i]=1: requester i wants a product; held until done[i]
//  a_in    in   N*DATA_W   packed operand A, slice i for requester i
//  b_in    in   N*DATA_W   packed operand B, slice i
//  grant   out  N          one-hot, requester currently being served
//  done    out  N          one-cycle pulse, result valid for that requester
//  result  out  2*DATA_W   signed product, held until the next completion
//  busy    out  1          high in every state except IDLE
//  m_start out  1          to mult.start
//  m_a     out  DATA_W     to mult.a, registered
//  m_b     out  DATA_W     to mult.b, registered
//  m_ready in   1          from mult.ready
//  m_c     in   2*DATA_W   from mult.c
// BEHAVIOUR
//  Reset: grant=0, done=0, result=0, busy=0, m_start=0, m_a=m_b=0, rr pointer=0, state IDLE.
//   Async; mid-operation reset abandons the op with no done. mult shares the same rst.
//  FSM IDLE -> START -> WAIT -> DONE -> IDLE:
//   IDLE:  if |req, pick winner = first set req at or after pointer (wrapping mod N).
//          Latch its a/b into m_a/m_b, set grant one-hot -> START. Else stay.
//   START: m_start=1 for exactly START_CYC cycles, m_ready ignored -> WAIT.
//   WAIT:  m_start=0; on m_ready=1: result<=m_c -> DONE.
//   DONE:  done[winner]=1 for one cycle, grant cleared, pointer<=winner+1 mod N -> IDLE.
//  Latency: req in IDLE to done pulse = 1+START_CYC+mult latency+1 cycles.
//  mult contract: ready drops by the second start cycle; ready stays high when result valid.
//  Requester rules:
//   - operands sampled once, in the IDLE cycle of the grant; later a_in changes ignored.
//   - req[i] dropped before grant: not served. Dropped after grant: op completes, done still pulses.
//   - req[i] still high in the cycle after done[i]: treated as a new request, lowest priority.
//  Simultaneous requests: round-robin order, no starvation; max wait = N-1 services.
//  Products: full 2*DATA_W signed, no truncation; -32768*-32768 = 1073741824.
//  New requests arriving during START/WAIT/DONE: queued by level, considered next IDLE.
//  Invariant: grant one-hot or zero; done one-hot or zero, never two cycles in a row for the same i.
// STRUCTURE
//  Package mult_pkg: DATA_W=16, PROD_W=32, typedef enum {IDLE,START,WAIT,DONE} sched_state_t,
//   typedef logic signed [DATA_W-1:0] operand_t, logic signed [PROD_W-1:0] product_t.
//  Sub-module rr_arbiter #(N): req, pointer -> one-hot winner, combinational.
//  mult_sched holds the FSM, operand/result registers, START_CYC counter, pointer.
//  mult is instantiated beside it in the top level, not inside.
// TESTING (bench: real mult, clk period 2)
//  1 req[0], a=49, b=23 -> grant=0001, m_start 2 cycles, done[0] pulse, result=1127.
//  2 req[1] a=-49 b=23 and req[2] a=-49 b=-23 together, pointer=1
//     -> served 1 then 2; results -1127, 1127; done pulses in that order.
//  3 all 4 req held, operands i*10 x 3 -> grant order 0,1,2,3,0...; each done once per round.
//  4 req[3] a=-32768 b=-32768 -> result=1073741824. a=32767, b=-32768 -> result=-1073709056.
//  5 rst asserted during WAIT -> all outputs 0 immediately, no done.
//     Next req[0] a=49 b=23 -> 1127 from pointer 0.
//  6 req[2] dropped before grant -> never served. a_in changed after grant -> result uses latched operands.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier scheduler and the multiplier itself.
`timescale 1ns/1ps
package mult_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } sched_state_t;

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [PROD_W-1:0] product_t;

endpackage

// File: rtl/mult.sv
// Sequential signed multiplier with a start/ready handshake.
// ready drops on the first accepted start and returns high with c valid
// LAT cycles later; c holds until the next operation completes.
`timescale 1ns/1ps
module mult
  import mult_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  operand_t a,
  input  operand_t b,
  output logic     ready,
  output product_t c
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  operand_t      a_q;
  operand_t      b_q;
  logic [CW-1:0] cnt;

  // accept operands when idle, count down the latency, then present the product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b1;
      c     <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
    end else if (ready) begin
      if (start) begin
        a_q   <= a;
        b_q   <= b;
        ready <= 1'b0;
        cnt   <= CW'(LAT - 1);
      end
    end else if (cnt == '0) begin
      c     <= product_t'(a_q) * product_t'(b_q);
      ready <= 1'b1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after the pointer, wrapping mod N.
// Purely combinational; the scheduler registers the outcome.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] winner_idx,
  output logic          any
);

  int            idx;
  logic [PW-1:0] sel;
  logic          found;

  // scan N positions starting at the pointer and keep the first hit
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    idx        = 0;
    sel        = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(pointer) + k;
      if (idx >= N) idx = idx - N;
      sel = idx[PW-1:0];
      if (!found && req[sel]) begin
        found       = 1'b1;
        winner[sel] = 1'b1;
        winner_idx  = sel;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential multiplier among N requesters.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for any req; latches winner operands and grant
//   START | m_start held high for START_CYC cycles, m_ready ignored
//   WAIT  | m_start low, waiting for m_ready to capture the product
//   DONE  | done pulse for the winner, grant cleared, pointer advanced
`timescale 1ns/1ps
module mult_sched
  import mult_pkg::*;
#(
  parameter int N         = 4,
  parameter int START_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*DATA_W-1:0] a_in,
  input  logic [N*DATA_W-1:0] b_in,
  output logic [N-1:0]        grant,
  output logic [N-1:0]        done,
  output product_t            result,
  output logic                busy,
  output logic                m_start,
  output operand_t            m_a,
  output operand_t            m_b,
  input  logic                m_ready,
  input  product_t            m_c
);

  localparam int PW = $clog2(N);
  localparam int CW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  sched_state_t  state;
  logic [PW-1:0] pointer;
  logic [PW-1:0] win_idx;
  logic [CW-1:0] start_cnt;

  logic [N-1:0]  arb_winner;
  logic [PW-1:0] arb_idx;
  logic          arb_any;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .req        (req),
    .pointer    (pointer),
    .winner     (arb_winner),
    .winner_idx (arb_idx),
    .any        (arb_any)
  );

  // scheduler FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pointer   <= '0;
      win_idx   <= '0;
      start_cnt <= '0;
      grant     <= '0;
      done      <= '0;
      result    <= '0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_a       <= '0;
      m_b       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            m_a       <= a_in[arb_idx*DATA_W +: DATA_W];
            m_b       <= b_in[arb_idx*DATA_W +: DATA_W];
            grant     <= arb_winner;
            win_idx   <= arb_idx;
            start_cnt <= CW'(START_CYC - 1);
            m_start   <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (start_cnt == '0) begin
            m_start <= 1'b0;
            state   <= WAIT;
          end else begin
            start_cnt <= start_cnt - 1'b1;
          end
        end
        WAIT: begin
          if (m_ready) begin
            result <= m_c;
            done   <= grant;
            state  <= DONE;
          end
        end
        DONE: begin
          done    <= '0;
          grant   <= '0;
          busy    <= 1'b0;
          pointer <= (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched driving the real mult model.
`timescale 1ns/100ps
module tb_mult_sched;
  import mult_pkg::*;

  localparam int N         = 4;
  localparam int START_CYC = 2;

  logic                clk  = 1'b0;
  logic                rst  = 1'b1;
  logic [N-1:0]        req  = '0;
  logic [N*DATA_W-1:0] a_in = '0;
  logic [N*DATA_W-1:0] b_in = '0;
  logic [N-1:0]        grant;
  logic [N-1:0]        done;
  product_t            result;
  logic                busy;
  logic                m_start;
  operand_t            m_a;
  operand_t            m_b;
  logic                m_ready;
  product_t            m_c;

  mult_sched #(.N(N), .START_CYC(START_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant), .done(done), .result(result), .busy(busy),
    .m_start(m_start), .m_a(m_a), .m_b(m_b), .m_ready(m_ready), .m_c(m_c)
  );

  mult #(.LAT(4)) u_mult (
    .clk(clk), .rst(rst), .start(m_start), .a(m_a), .b(m_b),
    .ready(m_ready), .c(m_c)
  );

  always #1 clk = ~clk;

  typedef struct {
    int idx;
    int res;
  } exp_t;

  exp_t         sb[$];
  int           checks    = 0;
  int           errors    = 0;
  bit           auto_drop = 1'b1;
  int           start_run = 0;
  logic [N-1:0] prev_done = '0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req_v);
    end
  endtask

  // monitor: invariants every cycle, scoreboard pop on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("grant_onehot0", 32'($onehot0(grant)), 1);
      chk("done_onehot0", 32'($onehot0(done)), 1);
      chk("done_repeat", 32'(done & prev_done), 0);
      if (m_start) begin
        start_run++;
      end else begin
        if (start_run != 0) chk("m_start_len", start_run, START_CYC);
        start_run = 0;
      end
      if (done != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=%b, required no pulse", done);
        end else begin
          e = sb.pop_front();
          chk("done_idx", 32'(done), 32'(1 << e.idx));
          chk("result", result, e.res);
          chk("grant_at_done", 32'(grant), 32'(done));
        end
      end
    end else begin
      start_run = 0;
    end
    prev_done = done;
    if (auto_drop) req = req & ~done;
  end

  task automatic issue(input int i, input int a, input int b, input bit push,
                       input int exp_res);
    exp_t e;
    a_in[i*DATA_W +: DATA_W] = a[DATA_W-1:0];
    b_in[i*DATA_W +: DATA_W] = b[DATA_W-1:0];
    req[i] = 1'b1;
    if (push) begin
      e.idx = i;
      e.res = exp_res;
      sb.push_back(e);
    end
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!busy) begin
      checks++;
      errors++;
      $display("FAIL %s: busy got 0 after 20 cycles, required 1", name);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_m_start"}, 32'(m_start), 0);
    chk({tag, "_m_a"}, m_a, 0);
    chk({tag, "_m_b"}, m_b, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // 1: single requester
    @(negedge clk);
    issue(0, 49, 23, 1, 1127);
    wait_busy("t1_busy");
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_m_a", m_a, 49);
    chk("t1_m_b", m_b, 23);
    wait_empty("t1");

    // 2: two requesters together, pointer at 1
    @(negedge clk);
    issue(1, -49, 23, 1, -1127);
    issue(2, -49, -23, 1, 1127);
    wait_empty("t2");

    // 3: all four held for two full rounds from pointer 0
    do_reset();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) issue(i, i * 10, 3, 0, 0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        exp_t e;
        e.idx = i;
        e.res = i * 30;
        sb.push_back(e);
      end
    n = 0;
    for (int cyc = 0; cyc < 400 && n < 8; cyc++) begin
      @(negedge clk);
      if (done != '0) n++;
    end
    req = '0;
    if (n < 8) begin
      checks++;
      errors++;
      $display("FAIL t3_rounds: got %0d done pulses, required 8", n);
    end
    auto_drop = 1'b1;
    wait_empty("t3");

    // 4: extreme operands
    @(negedge clk);
    issue(3, -32768, -32768, 1, 1073741824);
    wait_empty("t4a");
    @(negedge clk);
    issue(3, 32767, -32768, 1, -1073709056);
    wait_empty("t4b");

    // 5: reset during WAIT abandons the op
    @(negedge clk);
    issue(0, 49, 23, 0, 0);
    seen = 1'b0;
    n = 0;
    while (!(seen && !m_start && busy) && n < 40) begin
      @(negedge clk);
      if (m_start) seen = 1'b1;
      n++;
    end
    chk("t5_in_wait", 32'(seen && !m_start && busy), 1);
    rst = 1'b1;
    #0.2;
    check_all_zero("t5_rst");
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(0, 49, 23, 1, 1127);
    wait_busy("t5_busy");
    chk("t5_grant", 32'(grant), 32'h1);
    wait_empty("t5");

    // 6: req[2] dropped before grant, operand change after grant ignored
    @(negedge clk);
    issue(1, 7, -6, 1, -42);
    issue(2, 5, 5, 0, 0);
    wait_busy("t6_busy");
    chk("t6_grant", 32'(grant), 32'h2);
    @(negedge clk);
    req[2] = 1'b0;
    a_in[1*DATA_W +: DATA_W] = 16'sd1000;
    b_in[1*DATA_W +: DATA_W] = 16'sd1000;
    @(negedge clk);
    chk("t6_m_a_latched", m_a, 7);
    chk("t6_m_b_latched", m_b, -6);
    wait_empty("t6");
    repeat (10) @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_grant", 32'(grant), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
